// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned ALU_LAT  = 3;
  localparam int unsigned MEM_LAT  = 4;
  localparam int unsigned FWD_DIST = 2;

  // Forward-select code meaning "read the register file".
  localparam int unsigned FWD_RF = 0;

  // Width of a countdown that must hold values 0..max_lat.
  function automatic int unsigned cw(input int unsigned max_lat);
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: countdown of cycles until the pending write to this register lands.
module hazard_sb_entry #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          busy
);

  // A new issue overrides the decrement; otherwise count down to zero and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: RAW/WAW stall, forward selects and stall-cycle counter.
// Operand forwarding is enabled by defining HAZARD_FWD_EN.
module hazard_scoreboard #(
  parameter  int unsigned AW       = 2,
  parameter  int unsigned ALU_LAT  = hazard_pkg::ALU_LAT,
  parameter  int unsigned MEM_LAT  = hazard_pkg::MEM_LAT,
  parameter  int unsigned FWD_DIST = hazard_pkg::FWD_DIST,
  parameter  int unsigned PERF_W   = 16,
  localparam int unsigned CW       = hazard_pkg::cw(MEM_LAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              use_a,
  input  logic              use_b,
  input  logic [AW-1:0]     src_a,
  input  logic [AW-1:0]     src_b,
  input  logic              dst_we,
  input  logic [AW-1:0]     dst,
  input  logic              dst_is_load,
  output logic              stall,
  output logic [CW-1:0]     fwd_sel_a,
  output logic [CW-1:0]     fwd_sel_b,
  output logic [2**AW-1:0]  busy_mask,
  output logic [PERF_W-1:0] stall_cycles
);

  import hazard_pkg::*;

  localparam int unsigned NUM_REGS = 2**AW;
`ifdef HAZARD_FWD_EN
  localparam int unsigned LIMIT = FWD_DIST;
`else
  localparam int unsigned LIMIT = 0;
`endif

  if (ALU_LAT < 1 || MEM_LAT < ALU_LAT || FWD_DIST < 1 || FWD_DIST > ALU_LAT) begin : g_bad_params
    $error("hazard_scoreboard: inconsistent latency parameters");
  end

  logic [CW-1:0] cnt [NUM_REGS];
  logic [CW-1:0] cnt_a, cnt_b, cnt_d, new_lat;
  logic          raw_a, raw_b, waw, accept;

  // All hazard checks look at the pre-update counts, so src==dst sees the older writer.
  assign cnt_a   = cnt[src_a];
  assign cnt_b   = cnt[src_b];
  assign cnt_d   = cnt[dst];
  assign new_lat = dst_is_load ? CW'(MEM_LAT) : CW'(ALU_LAT);

  assign raw_a  = issue_valid & use_a  & (cnt_a > CW'(LIMIT));
  assign raw_b  = issue_valid & use_b  & (cnt_b > CW'(LIMIT));
  assign waw    = issue_valid & dst_we & (cnt_d > new_lat);
  assign stall  = raw_a | raw_b | waw;
  assign accept = issue_valid & ~stall;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(.CW(CW)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (accept & dst_we & (dst == AW'(r))),
      .load_val (new_lat),
      .cnt      (cnt[r]),
      .busy     (busy_mask[r])
    );
  end

`ifdef HAZARD_FWD_EN
  // cnt==1 is still in flight (no RF bypass), so it is forwarded like any other close result.
  assign fwd_sel_a = (use_a && cnt_a != '0 && cnt_a <= CW'(FWD_DIST)) ? cnt_a : CW'(FWD_RF);
  assign fwd_sel_b = (use_b && cnt_b != '0 && cnt_b <= CW'(FWD_DIST)) ? cnt_b : CW'(FWD_RF);
`else
  assign fwd_sel_a = CW'(FWD_RF);
  assign fwd_sel_b = CW'(FWD_RF);
`endif

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule
